// File: rtl/sdram_port_arbiter.sv
// Two-client slot sequencer in front of the single-port 8-bit sdram controller.
// Define SDRAM_ARB_ROTATE_EN for round-robin A/B arbitration; otherwise A has fixed priority.
module sdram_port_arbiter #(
    parameter int SLOT_LEN    = 8,
    parameter int DATA_TAP    = 6,
    parameter int REFRESH_INT = 480,
    parameter int INIT_CYCLES = 320
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [24:0] a_addr,
    input  logic [7:0]  a_din,
    output logic        a_ack,
    output logic [7:0]  a_dout,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [24:0] b_addr,
    input  logic [7:0]  b_din,
    output logic        b_ack,
    output logic [7:0]  b_dout,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_refresh,
    input  logic [7:0]  mem_dout,
    output logic        busy
);
    localparam int SW = $clog2(SLOT_LEN);
    localparam int RW = $clog2(REFRESH_INT);
    localparam int IW = $clog2(INIT_CYCLES);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_REFRESH} state_t;

    state_t        state, state_next;
    logic [IW-1:0] init_cnt;
    logic [SW-1:0] slot_cnt;
    logic [RW-1:0] ref_cnt;
    logic          ref_pend;
    logic          gnt_b;
    logic          pick_b;
    logic          start_acc, start_ref;

`ifdef SDRAM_ARB_ROTATE_EN
    // Reset value of 1 means "B served last", so A wins the first tie.
    logic last_b;
    assign pick_b = b_req && (!a_req || !last_b);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       last_b <= 1'b1;
        else if (start_acc) last_b <= pick_b;
    end
`else
    assign pick_b = b_req && !a_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_INIT;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_acc  = 1'b0;
        start_ref  = 1'b0;
        case (state)
            S_INIT: begin
                if (init_cnt == IW'(INIT_CYCLES - 1)) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (ref_pend) begin
                    start_ref  = 1'b1;
                    state_next = S_REFRESH;
                end else if (a_req || b_req) begin
                    start_acc  = 1'b1;
                    state_next = S_ACCESS;
                end
            end
            default: begin
                if (slot_cnt == SW'(SLOT_LEN - 1)) state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt    <= '0;
            slot_cnt    <= '0;
            ref_cnt     <= '0;
            ref_pend    <= 1'b0;
            gnt_b       <= 1'b0;
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_refresh <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_dout      <= '0;
            b_dout      <= '0;
            busy        <= 1'b0;
        end else begin
            init_cnt <= (state == S_INIT) ? init_cnt + IW'(1) : '0;
            busy     <= (state_next != S_IDLE);

            // A new expiry wins over the clear; a second expiry while pending is dropped.
            if (state != S_INIT) begin
                if (ref_cnt == RW'(REFRESH_INT - 1)) begin
                    ref_cnt  <= '0;
                    ref_pend <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt + RW'(1);
                    if (start_ref) ref_pend <= 1'b0;
                end
            end

            if (start_acc || start_ref)
                slot_cnt <= '0;
            else if (state == S_ACCESS || state == S_REFRESH)
                slot_cnt <= slot_cnt + SW'(1);

            // Strobes cover slot cycles 0..3 only, giving the controller a fresh edge per slot.
            mem_ce      <= start_acc || (state == S_ACCESS  && slot_cnt < SW'(3));
            mem_refresh <= start_ref || (state == S_REFRESH && slot_cnt < SW'(3));

            if (start_acc) begin
                gnt_b    <= pick_b;
                mem_we   <= pick_b ? b_we   : a_we;
                mem_addr <= pick_b ? b_addr : a_addr;
                mem_din  <= pick_b ? b_din  : a_din;
            end else if (state_next != S_ACCESS) begin
                mem_we <= 1'b0;
            end

            a_ack <= (state == S_ACCESS) && (slot_cnt == SW'(SLOT_LEN - 2)) && !gnt_b;
            b_ack <= (state == S_ACCESS) && (slot_cnt == SW'(SLOT_LEN - 2)) &&  gnt_b;

            if (state == S_ACCESS && slot_cnt == SW'(DATA_TAP) && !mem_we) begin
                if (gnt_b) b_dout <= mem_dout;
                else       a_dout <= mem_dout;
            end
        end
    end
endmodule
